// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst master: AMCI command/stream interface on one side, AXI4 on the other.
// Write and read channels run independently; commands that are illegal or cross a 4 KB page are rejected in IDLE.
module axi4_burst_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST      = 256,
    parameter int AXI_ID         = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    // AMCI write side
    input  logic [AXI_ADDR_WIDTH-1:0]   AMCI_WADDR,
    input  logic [7:0]                  AMCI_WLEN,
    input  logic                        AMCI_WRITE,
    input  logic [AXI_DATA_WIDTH-1:0]   AMCI_WDATA,
    input  logic                        AMCI_WDVALID,
    output logic                        AMCI_WDREADY,
    output logic [1:0]                  AMCI_WRESP,
    output logic                        AMCI_WIDLE,
    // AMCI read side
    input  logic [AXI_ADDR_WIDTH-1:0]   AMCI_RADDR,
    input  logic [7:0]                  AMCI_RLEN,
    input  logic                        AMCI_READ,
    output logic [AXI_DATA_WIDTH-1:0]   AMCI_RDATA,
    output logic                        AMCI_RDVALID,
    output logic                        AMCI_RDLAST,
    input  logic                        AMCI_RDREADY,
    output logic [1:0]                  AMCI_RRESP,
    output logic                        AMCI_RIDLE,
    // AXI write address
    output logic [3:0]                  AXI_AWID,
    output logic [AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    output logic [7:0]                  AXI_AWLEN,
    output logic [2:0]                  AXI_AWSIZE,
    output logic [1:0]                  AXI_AWBURST,
    output logic                        AXI_AWLOCK,
    output logic [3:0]                  AXI_AWCACHE,
    output logic [3:0]                  AXI_AWQOS,
    output logic [2:0]                  AXI_AWPROT,
    output logic                        AXI_AWVALID,
    input  logic                        AXI_AWREADY,
    // AXI write data / response
    output logic [AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
    output logic                        AXI_WLAST,
    output logic                        AXI_WVALID,
    input  logic                        AXI_WREADY,
    input  logic [1:0]                  AXI_BRESP,
    input  logic                        AXI_BVALID,
    output logic                        AXI_BREADY,
    // AXI read address
    output logic [3:0]                  AXI_ARID,
    output logic [AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    output logic [7:0]                  AXI_ARLEN,
    output logic [2:0]                  AXI_ARSIZE,
    output logic [1:0]                  AXI_ARBURST,
    output logic                        AXI_ARLOCK,
    output logic [3:0]                  AXI_ARCACHE,
    output logic [3:0]                  AXI_ARQOS,
    output logic [2:0]                  AXI_ARPROT,
    output logic                        AXI_ARVALID,
    input  logic                        AXI_ARREADY,
    // AXI read data
    input  logic [AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]                  AXI_RRESP,
    input  logic                        AXI_RLAST,
    input  logic                        AXI_RVALID,
    output logic                        AXI_RREADY,
    // FSM state observation
    output logic [1:0]                  wr_state_dbg,
    output logic                        rd_state_dbg
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BYTES - 1);

    // Handshake rule on every channel: a beat transfers on a rising clk edge where valid and ready are both high.

    // True when the burst is too long or its last byte lands in the next 4 KB page.
    function automatic logic cmd_bad(input logic [11:0] off, input logic [7:0] len);
        logic [31:0] start_off;
        logic [31:0] span;
        start_off = 32'(off) & ~32'(BYTES - 1);
        span      = (32'(len) + 32'd1) << SIZE;
        return (32'(len) > 32'(MAX_BURST - 1)) || (start_off + span > 32'd4096);
    endfunction

    assign AXI_AWID    = 4'(AXI_ID);
    assign AXI_AWSIZE  = 3'(SIZE);
    assign AXI_AWBURST = 2'b01;
    assign AXI_AWLOCK  = 1'b0;
    assign AXI_AWCACHE = 4'd2;
    assign AXI_AWQOS   = 4'd0;
    assign AXI_AWPROT  = 3'd0;
    assign AXI_WSTRB   = '1;
    assign AXI_ARID    = 4'(AXI_ID);
    assign AXI_ARSIZE  = 3'(SIZE);
    assign AXI_ARBURST = 2'b01;
    assign AXI_ARLOCK  = 1'b0;
    assign AXI_ARCACHE = 4'd2;
    assign AXI_ARQOS   = 4'd0;
    assign AXI_ARPROT  = 3'd0;

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_ACTIVE} rd_state_t;

    wr_state_t  wr_state;
    logic       aw_done;
    logic       w_done;
    logic [7:0] w_cnt;
    logic       w_active;
    logic       aw_hs;
    logic       w_hs;
    logic       w_last_hs;

    assign w_active     = (wr_state == W_ADDR_DATA) && !w_done;
    assign AXI_WDATA    = AMCI_WDATA;
    assign AXI_WVALID   = w_active && AMCI_WDVALID;
    assign AMCI_WDREADY = w_active && AXI_WREADY;
    assign AXI_WLAST    = (w_cnt == AXI_AWLEN);
    assign aw_hs        = AXI_AWVALID && AXI_AWREADY;
    assign w_hs         = AXI_WVALID && AXI_WREADY;
    assign w_last_hs    = w_hs && AXI_WLAST;
    assign AMCI_WIDLE   = (wr_state == W_IDLE) && !AMCI_WRITE;
    assign wr_state_dbg = wr_state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state    <= W_IDLE;
            AXI_AWVALID <= 1'b0;
            AXI_AWADDR  <= '0;
            AXI_AWLEN   <= '0;
            AXI_BREADY  <= 1'b0;
            AMCI_WRESP  <= 2'b00;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            w_cnt       <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (AMCI_WRITE) begin
                        if (cmd_bad(AMCI_WADDR[11:0], AMCI_WLEN)) begin
                            AMCI_WRESP <= 2'b10;
                        end else begin
                            AXI_AWADDR  <= AMCI_WADDR & ALIGN_MASK;
                            AXI_AWLEN   <= AMCI_WLEN;
                            AXI_AWVALID <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            w_cnt       <= '0;
                            wr_state    <= W_ADDR_DATA;
                        end
                    end
                end
                W_ADDR_DATA: begin
                    if (aw_hs) begin
                        AXI_AWVALID <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs)      w_cnt  <= w_cnt + 8'd1;
                    if (w_last_hs) w_done <= 1'b1;
                    // AW and the last W beat may complete in either order or together.
                    if ((aw_done || aw_hs) && (w_done || w_last_hs)) begin
                        AXI_BREADY <= 1'b1;
                        wr_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (AXI_BVALID) begin
                        AMCI_WRESP <= AXI_BRESP;
                        AXI_BREADY <= 1'b0;
                        wr_state   <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    rd_state_t  rd_state;
    logic [1:0] rd_acc;
    logic [1:0] rd_worst;
    logic       rd_active;
    logic       r_hs;

    assign rd_active    = (rd_state == R_ACTIVE);
    assign AMCI_RDATA   = AXI_RDATA;
    assign AMCI_RDVALID = rd_active && AXI_RVALID;
    assign AMCI_RDLAST  = rd_active && AXI_RLAST;
    assign AXI_RREADY   = rd_active && AMCI_RDREADY;
    assign r_hs         = AXI_RVALID && AXI_RREADY;
    assign rd_worst     = (AXI_RRESP > rd_acc) ? AXI_RRESP : rd_acc;
    assign AMCI_RIDLE   = (rd_state == R_IDLE) && !AMCI_READ;
    assign rd_state_dbg = rd_state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state    <= R_IDLE;
            AXI_ARVALID <= 1'b0;
            AXI_ARADDR  <= '0;
            AXI_ARLEN   <= '0;
            AMCI_RRESP  <= 2'b00;
            rd_acc      <= 2'b00;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (AMCI_READ) begin
                        if (cmd_bad(AMCI_RADDR[11:0], AMCI_RLEN)) begin
                            AMCI_RRESP <= 2'b10;
                        end else begin
                            AXI_ARADDR  <= AMCI_RADDR & ALIGN_MASK;
                            AXI_ARLEN   <= AMCI_RLEN;
                            AXI_ARVALID <= 1'b1;
                            rd_acc      <= 2'b00;
                            rd_state    <= R_ACTIVE;
                        end
                    end
                end
                R_ACTIVE: begin
                    if (AXI_ARVALID && AXI_ARREADY) AXI_ARVALID <= 1'b0;
                    // RLAST alone ends the burst; the worst response seen is sticky.
                    if (r_hs) begin
                        rd_acc <= rd_worst;
                        if (AXI_RLAST) begin
                            AMCI_RRESP <= rd_worst;
                            rd_state   <= R_IDLE;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench plays the AMCI user and the AXI slave,
// checking every point against hand-computed values.
module tb_axi4_burst_master;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] AMCI_WADDR, AMCI_RADDR, AMCI_WDATA, AMCI_RDATA;
    logic [7:0]  AMCI_WLEN, AMCI_RLEN;
    logic        AMCI_WRITE, AMCI_READ, AMCI_WDVALID, AMCI_WDREADY, AMCI_WIDLE, AMCI_RIDLE;
    logic        AMCI_RDVALID, AMCI_RDLAST, AMCI_RDREADY;
    logic [1:0]  AMCI_WRESP, AMCI_RRESP;
    logic [3:0]  AXI_AWID, AXI_AWCACHE, AXI_AWQOS, AXI_ARID, AXI_ARCACHE, AXI_ARQOS, AXI_WSTRB;
    logic [31:0] AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_RDATA;
    logic [7:0]  AXI_AWLEN, AXI_ARLEN;
    logic [2:0]  AXI_AWSIZE, AXI_AWPROT, AXI_ARSIZE, AXI_ARPROT;
    logic [1:0]  AXI_AWBURST, AXI_ARBURST, AXI_BRESP, AXI_RRESP;
    logic        AXI_AWLOCK, AXI_AWVALID, AXI_AWREADY, AXI_WLAST, AXI_WVALID, AXI_WREADY;
    logic        AXI_BVALID, AXI_BREADY, AXI_ARLOCK, AXI_ARVALID, AXI_ARREADY;
    logic        AXI_RLAST, AXI_RVALID, AXI_RREADY;
    logic [1:0]  wr_state_dbg;
    logic        rd_state_dbg;

    int          total = 0;
    int          bad = 0;
    int          n_w, n_r, stalls, budget;
    logic        took;
    logic [31:0] exp_d;
    logic [31:0] exp_q[$];

    axi4_burst_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .MAX_BURST(256), .AXI_ID(1)) dut (
        .clk(clk), .resetn(resetn),
        .AMCI_WADDR(AMCI_WADDR), .AMCI_WLEN(AMCI_WLEN), .AMCI_WRITE(AMCI_WRITE),
        .AMCI_WDATA(AMCI_WDATA), .AMCI_WDVALID(AMCI_WDVALID), .AMCI_WDREADY(AMCI_WDREADY),
        .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
        .AMCI_RADDR(AMCI_RADDR), .AMCI_RLEN(AMCI_RLEN), .AMCI_READ(AMCI_READ),
        .AMCI_RDATA(AMCI_RDATA), .AMCI_RDVALID(AMCI_RDVALID), .AMCI_RDLAST(AMCI_RDLAST),
        .AMCI_RDREADY(AMCI_RDREADY), .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
        .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN),
        .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST), .AXI_AWLOCK(AXI_AWLOCK),
        .AXI_AWCACHE(AXI_AWCACHE), .AXI_AWQOS(AXI_AWQOS), .AXI_AWPROT(AXI_AWPROT),
        .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
        .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARID(AXI_ARID), .AXI_ARADDR(AXI_ARADDR), .AXI_ARLEN(AXI_ARLEN),
        .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST), .AXI_ARLOCK(AXI_ARLOCK),
        .AXI_ARCACHE(AXI_ARCACHE), .AXI_ARQOS(AXI_ARQOS), .AXI_ARPROT(AXI_ARPROT),
        .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RLAST(AXI_RLAST),
        .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        resetn = 1'b0;
        AMCI_WADDR = '0; AMCI_WLEN = '0; AMCI_WRITE = 1'b0; AMCI_WDATA = '0; AMCI_WDVALID = 1'b0;
        AMCI_RADDR = '0; AMCI_RLEN = '0; AMCI_READ = 1'b0; AMCI_RDREADY = 1'b0;
        AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1; AXI_BRESP = 2'b00; AXI_BVALID = 1'b0;
        AXI_ARREADY = 1'b1; AXI_RDATA = '0; AXI_RRESP = 2'b00; AXI_RLAST = 1'b0; AXI_RVALID = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        settle();

        // Reset state and constant outputs
        chk("rst_awvalid", AXI_AWVALID, 0);
        chk("rst_arvalid", AXI_ARVALID, 0);
        chk("rst_bready", AXI_BREADY, 0);
        chk("rst_rready", AXI_RREADY, 0);
        chk("rst_wdready", AMCI_WDREADY, 0);
        chk("rst_rdvalid", AMCI_RDVALID, 0);
        chk("rst_wresp", AMCI_WRESP, 0);
        chk("rst_rresp", AMCI_RRESP, 0);
        chk("rst_widle", AMCI_WIDLE, 1);
        chk("rst_ridle", AMCI_RIDLE, 1);
        chk("rst_wr_state", wr_state_dbg, 0);
        chk("awid", AXI_AWID, 1);
        chk("awsize", AXI_AWSIZE, 2);
        chk("awburst", AXI_AWBURST, 1);
        chk("awcache", AXI_AWCACHE, 2);
        chk("arcache", AXI_ARCACHE, 2);
        chk("wstrb", AXI_WSTRB, 4'hF);

        // Write 0x1000 LEN=3, slave always ready
        AMCI_WADDR = 32'h1000; AMCI_WLEN = 8'd3; AMCI_WRITE = 1'b1;
        settle();
        chk("t1_widle_on_start", AMCI_WIDLE, 0);
        tick();
        AMCI_WRITE = 1'b0;
        settle();
        chk("t1_awvalid", AXI_AWVALID, 1);
        chk("t1_awaddr", AXI_AWADDR, 32'h1000);
        chk("t1_awlen", AXI_AWLEN, 3);
        for (int i = 0; i < 4; i++) begin
            AMCI_WDVALID = 1'b1; AMCI_WDATA = 32'hA0 + 32'(i);
            settle();
            chk("t1_wvalid", AXI_WVALID, 1);
            chk("t1_wdata", AXI_WDATA, 32'hA0 + 32'(i));
            chk("t1_wlast", AXI_WLAST, (i == 3) ? 1 : 0);
            chk("t1_wdready", AMCI_WDREADY, 1);
            tick();
        end
        AMCI_WDVALID = 1'b0;
        settle();
        chk("t1_awvalid_drop", AXI_AWVALID, 0);
        chk("t1_bready", AXI_BREADY, 1);
        AMCI_WDVALID = 1'b1;
        settle();
        chk("t1_wvalid_after_last", AXI_WVALID, 0);
        AMCI_WDVALID = 1'b0;
        AXI_BVALID = 1'b1; AXI_BRESP = 2'b00;
        tick();
        AXI_BVALID = 1'b0;
        settle();
        chk("t1_widle", AMCI_WIDLE, 1);
        chk("t1_wresp", AMCI_WRESP, 0);
        chk("t1_bready_drop", AXI_BREADY, 0);

        // Write 0x2004 LEN=0, WREADY low 5 cycles, AWREADY 10 cycles late
        AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0;
        AMCI_WADDR = 32'h2004; AMCI_WLEN = 8'd0; AMCI_WRITE = 1'b1;
        tick();
        AMCI_WRITE = 1'b0;
        AMCI_WDVALID = 1'b1; AMCI_WDATA = 32'h55;
        settle();
        chk("t2_awaddr", AXI_AWADDR, 32'h2004);
        for (int i = 0; i < 5; i++) begin
            chk("t2_wvalid_stall", AXI_WVALID, 1);
            chk("t2_wdready_stall", AMCI_WDREADY, 0);
            chk("t2_bready_early", AXI_BREADY, 0);
            tick();
        end
        AXI_WREADY = 1'b1;
        settle();
        chk("t2_wlast", AXI_WLAST, 1);
        chk("t2_wdready", AMCI_WDREADY, 1);
        tick();
        AXI_WREADY = 1'b0; AMCI_WDVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_bready_wait_aw", AXI_BREADY, 0);
            chk("t2_awvalid_held", AXI_AWVALID, 1);
            tick();
        end
        AXI_AWREADY = 1'b1;
        tick();
        settle();
        chk("t2_bready", AXI_BREADY, 1);
        chk("t2_awvalid_drop", AXI_AWVALID, 0);
        AXI_BVALID = 1'b1; AXI_BRESP = 2'b01;
        settle();
        chk("t2_widle_before_b", AMCI_WIDLE, 0);
        tick();
        AXI_BVALID = 1'b0;
        settle();
        chk("t2_widle", AMCI_WIDLE, 1);
        chk("t2_wresp", AMCI_WRESP, 1);
        AXI_WREADY = 1'b1;

        // Read 0x3000 LEN=7 with random AMCI_RDREADY stalls, beat 5 SLVERR
        AMCI_RADDR = 32'h3000; AMCI_RLEN = 8'd7; AMCI_READ = 1'b1;
        tick();
        AMCI_READ = 1'b0;
        settle();
        chk("t3_arvalid", AXI_ARVALID, 1);
        chk("t3_araddr", AXI_ARADDR, 32'h3000);
        chk("t3_arlen", AXI_ARLEN, 7);
        tick();
        settle();
        chk("t3_arvalid_drop", AXI_ARVALID, 0);
        for (int b = 0; b < 8; b++) exp_q.push_back(32'hB0 + 32'(b));
        n_r = 0;
        for (int b = 0; b < 8; b++) begin
            AXI_RVALID = 1'b1; AXI_RDATA = 32'hB0 + 32'(b);
            AXI_RLAST = (b == 7); AXI_RRESP = (b == 4) ? 2'b10 : 2'b00;
            stalls = 0; took = 1'b0; budget = 0;
            while (!took && budget < 20) begin
                AMCI_RDREADY = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                settle();
                chk("t3_rdvalid", AMCI_RDVALID, 1);
                chk("t3_rready", AXI_RREADY, AMCI_RDREADY);
                if (AMCI_RDREADY) begin
                    took = 1'b1;
                    exp_d = exp_q.pop_front();
                    chk("t3_rdata", AMCI_RDATA, exp_d);
                    chk("t3_rdlast", AMCI_RDLAST, (b == 7) ? 1 : 0);
                    if (b == 7) chk("t3_rresp_before_last", AMCI_RRESP, 0);
                    n_r++;
                end else begin
                    stalls++;
                end
                budget++;
                tick();
            end
            chk("t3_beat_budget", took, 1);
        end
        AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; AXI_RRESP = 2'b00; AMCI_RDREADY = 1'b0;
        settle();
        chk("t3_beats", n_r, 8);
        chk("t3_ridle", AMCI_RIDLE, 1);
        chk("t3_rresp", AMCI_RRESP, 2'b10);

        // Write 0x0FF8 LEN=3 crosses 4 KB: rejected
        AMCI_WADDR = 32'h0FF8; AMCI_WLEN = 8'd3; AMCI_WRITE = 1'b1;
        AMCI_WDVALID = 1'b1; AMCI_WDATA = 32'h77;
        settle();
        chk("t4_widle_low", AMCI_WIDLE, 0);
        tick();
        AMCI_WRITE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_awvalid", AXI_AWVALID, 0);
            chk("t4_wdready", AMCI_WDREADY, 0);
            chk("t4_widle", AMCI_WIDLE, 1);
            chk("t4_wresp", AMCI_WRESP, 2'b10);
            tick();
        end
        AMCI_WDVALID = 1'b0;

        // Read 0x1FFC LEN=0 ends exactly on the page: accepted
        AMCI_RADDR = 32'h1FFC; AMCI_RLEN = 8'd0; AMCI_READ = 1'b1;
        tick();
        AMCI_READ = 1'b0;
        settle();
        chk("t4_arvalid_edge", AXI_ARVALID, 1);
        AXI_RVALID = 1'b1; AXI_RLAST = 1'b1; AXI_RRESP = 2'b11; AXI_RDATA = 32'h99; AMCI_RDREADY = 1'b1;
        tick();
        AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; AXI_RRESP = 2'b00;
        settle();
        chk("t4_ridle", AMCI_RIDLE, 1);
        chk("t4_rresp", AMCI_RRESP, 2'b11);

        // Concurrent write LEN=15 and read LEN=15
        AMCI_WADDR = 32'h5000; AMCI_WLEN = 8'd15; AMCI_WRITE = 1'b1;
        AMCI_RADDR = 32'h6000; AMCI_RLEN = 8'd15; AMCI_READ = 1'b1;
        tick();
        AMCI_WRITE = 1'b0; AMCI_READ = 1'b0;
        settle();
        chk("t5_awvalid", AXI_AWVALID, 1);
        chk("t5_arvalid", AXI_ARVALID, 1);
        n_w = 0; n_r = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'hD00 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            AMCI_WDVALID = 1'b1; AMCI_WDATA = 32'hC00 + 32'(i);
            AXI_RVALID = 1'b1; AXI_RDATA = 32'hD00 + 32'(i); AXI_RLAST = (i == 15);
            settle();
            chk("t5_wdata", AXI_WDATA, 32'hC00 + 32'(i));
            chk("t5_wlast", AXI_WLAST, (i == 15) ? 1 : 0);
            exp_d = exp_q.pop_front();
            chk("t5_rdata", AMCI_RDATA, exp_d);
            chk("t5_rdlast", AMCI_RDLAST, (i == 15) ? 1 : 0);
            if (AXI_WVALID && AXI_WREADY) n_w++;
            if (AMCI_RDVALID && AMCI_RDREADY) n_r++;
            tick();
        end
        AMCI_WDVALID = 1'b0; AXI_RVALID = 1'b0; AXI_RLAST = 1'b0;
        settle();
        chk("t5_wbeats", n_w, 16);
        chk("t5_rbeats", n_r, 16);
        chk("t5_ridle", AMCI_RIDLE, 1);
        chk("t5_rresp", AMCI_RRESP, 0);
        chk("t5_bready", AXI_BREADY, 1);
        AXI_BVALID = 1'b1; AXI_BRESP = 2'b11;
        tick();
        AXI_BVALID = 1'b0;
        settle();
        chk("t5_widle", AMCI_WIDLE, 1);
        chk("t5_wresp", AMCI_WRESP, 2'b11);

        // Reset mid-burst at write beat 2 of LEN=7
        AMCI_WADDR = 32'h7000; AMCI_WLEN = 8'd7; AMCI_WRITE = 1'b1;
        tick();
        AMCI_WRITE = 1'b0;
        AMCI_WDVALID = 1'b1;
        AMCI_WDATA = 32'hE0;
        tick();
        AMCI_WDATA = 32'hE1;
        tick();
        AMCI_WDATA = 32'hE2;
        AXI_RVALID = 1'b1; AMCI_RDREADY = 1'b1;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        chk("t6_awvalid", AXI_AWVALID, 0);
        chk("t6_wvalid", AXI_WVALID, 0);
        chk("t6_wdready", AMCI_WDREADY, 0);
        chk("t6_bready", AXI_BREADY, 0);
        chk("t6_arvalid", AXI_ARVALID, 0);
        chk("t6_rready", AXI_RREADY, 0);
        chk("t6_rdvalid", AMCI_RDVALID, 0);
        chk("t6_widle", AMCI_WIDLE, 1);
        chk("t6_ridle", AMCI_RIDLE, 1);
        chk("t6_wresp", AMCI_WRESP, 0);
        AMCI_WDVALID = 1'b0; AXI_RVALID = 1'b0;
        AMCI_WADDR = 32'h4000; AMCI_WLEN = 8'd0; AMCI_WRITE = 1'b1;
        tick();
        AMCI_WRITE = 1'b0;
        AMCI_WDVALID = 1'b1; AMCI_WDATA = 32'hF0;
        settle();
        chk("t6_new_awvalid", AXI_AWVALID, 1);
        chk("t6_new_awaddr", AXI_AWADDR, 32'h4000);
        chk("t6_new_wlast", AXI_WLAST, 1);
        tick();
        AMCI_WDVALID = 1'b0;
        settle();
        chk("t6_new_bready", AXI_BREADY, 1);
        AXI_BVALID = 1'b1; AXI_BRESP = 2'b00;
        tick();
        AXI_BVALID = 1'b0;
        settle();
        chk("t6_new_widle", AMCI_WIDLE, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
